ordering_host: RTL and testbench
================================

# ordering_host

Host-side initiator for the replica ordering port. It streams city orderings from a host write stream into the array's `ordering_write`/`ordering_wdata` beats. It also drains orderings back out through `ordering_read`/`ordering_rdata` into a host read stream, pacing every request against `ordering_ready`. It sits between the host bus adapter and the replica top, and owns the beat/replica counting and the read-return buffering that the array side does not provide.

## Interface
Parameters:
- `replica_num`, 32: number of replicas in the ordering chain.
- `beats_per_replica`, `ORD_BEATS` (package): 64-bit beats per replica ordering (city_num/8).
- `fifo_depth`, 4: read-return buffer depth; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_write` in 1: pulse; start a write transfer of all orderings.
- `cmd_read` in 1: pulse; start a read transfer of all orderings.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at transfer completion.
- `s_valid` in 1: host write beat valid.
- `s_ready` out 1: host write beat accepted.
- `s_data` in 64: host write beat; byte k = city index k.
- `m_valid` out 1: host read beat valid.
- `m_ready` in 1: host read beat accepted.
- `m_data` out 64: host read beat.
- `ordering_write` out 1: write beat strobe to array.
- `ordering_wdata` out [7:0][7:0]: write beat.
- `ordering_read` out 1: read request strobe to array.
- `ordering_ready` in 1: array can accept a write beat or read request this cycle.
- `ordering_rdata` in [7:0][7:0]: read data, valid the cycle after an accepted `ordering_read`.
- `checksum` out 16: byte sum of the last transfer (see Configuration).

## Operation
- Total beats per transfer: `T = replica_num*beats_per_replica`. Beat counter width is `$clog2(T+1)`.
- FSM states:
  - IDLE: `cmd_write` moves to WRITE; `cmd_read` moves to READ. If both are asserted in the same cycle, WRITE wins and the read command is dropped. Commands in any other state are ignored.
  - WRITE:
    - `s_ready = ordering_ready & (wcnt < T)`.
    - `ordering_write = s_valid & s_ready`; `ordering_wdata = s_data`, passed combinationally.
    - `wcnt` increments per beat. When `wcnt` reaches T, go to DONE.
  - READ:
    - Issue `ordering_read` when `ordering_ready & (rcnt_issued < T) & (fifo_count + inflight < fifo_depth)`.
    - `inflight` is 1 the cycle after an issue. Returned data is pushed into the FIFO unconditionally; the credit check guarantees space.
    - `m_valid` = FIFO not empty; a pop occurs on `m_valid & m_ready`.
    - When popped count reaches T, go to DONE.
  - DONE: one cycle; `done=1`; then IDLE.
- `busy = (state != IDLE)`, and is therefore high during DONE.
- Byte order is preserved end to end; no reordering or replica re-indexing.

## Timing
- Reset values: `busy=0`, `done=0`, `s_ready=0`, `m_valid=0`, `ordering_write=0`, `ordering_read=0`, `checksum=0`. Reset also clears counters and the FIFO.
- Reset mid-transfer: return to IDLE next cycle, flush the FIFO, drop in-flight read data, no `done`.
- Command to first strobe: `cmd_*` at cycle c → state change at c+1 → first `ordering_write`/`ordering_read` possible at c+1.
- Write throughput: 1 beat/cycle while `s_valid` and `ordering_ready` are high.
- Read throughput: 1 beat/cycle once the FIFO pipeline is primed with `m_ready=1`. Latency from `ordering_read` to `m_valid` is 2 cycles (array +1, FIFO register +1).
- Read-side backpressure: `m_ready=0` stalls issue after at most `fifo_depth` outstanding beats; no beat is ever lost.
- `ordering_ready` low: no strobe that cycle; counters hold.
- DONE follows the cycle in which the T-th beat is written or popped.

## Configuration
`ORDERING_HOST_CHECKSUM_EN`:
- Defined: a 16-bit accumulator is cleared on command acceptance. It adds all 8 bytes of each transferred beat, mod 2^16: written beats in WRITE, popped beats in READ. `checksum` presents the accumulator, holding its value after DONE.
- Undefined: the accumulator is absent and `checksum` is tied to 0.

## Structure
- Package additions to `replica_pkg`: `ordering_word_t` (logic [7:0][7:0]) and `ORD_BEATS` (city_num/8).
- Sub-module `ordering_host_fifo`: synchronous FIFO with parameter depth, push/pop/count/empty; registered output data; flushed by reset.

## Test plan
- Write, replica_num=2, beats=4: `cmd_write`, 8 beats 0x0706050403020100+i, `s_valid` held → 8 `ordering_write` in consecutive cycles with matching data; `done` once; checksum (EN) = 8*0x1C + 8*8*... as computed by model.
- Write with `ordering_ready` toggling every other cycle → `s_ready` tracks it; exactly 8 strobes; no beat duplicated.
- Read with `m_ready` held low for 10 cycles → exactly 4 `ordering_read` issued, then stall. On release, all 8 beats emerge in order and `done` asserts once.
- Simultaneous `cmd_write` and `cmd_read` in IDLE → WRITE performed, no `ordering_read` issued. `cmd_read` during WRITE is ignored.
- Reset asserted after 3 read beats popped → next cycle `busy=0`, `m_valid=0`, no `done`. A new `cmd_read` then transfers the full 8 beats.
- Build without `ORDERING_HOST_CHECKSUM_EN` → `checksum`=0 throughout the write scenario.

Source files
------------

// File: rtl/replica_pkg.sv
// rtl/replica_pkg.sv - shared replica ordering types and constants
package replica_pkg;

    localparam int CITY_NUM  = 32;
    localparam int ORD_BEATS = CITY_NUM / 8;

    typedef logic [7:0][7:0] ordering_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } ord_state_e;

    function automatic logic [15:0] byte_sum(input ordering_word_t w);
        logic [15:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            s = s + 16'(w[k]);
        end
        return s;
    endfunction

endpackage

// File: rtl/ordering_host_fifo.sv
// rtl/ordering_host_fifo.sv - read-return buffer between the array and the host read stream
// Output data is taken straight from the storage registers; reset flushes pointers and count.
module ordering_host_fifo #(
    parameter int depth = 4,
    parameter int width = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [width-1:0]             din_i,
    input  logic                         pop_i,
    output logic [width-1:0]             dout_o,
    output logic [$clog2(depth+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q < DEPTH_C);
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ordering_host.sv
// rtl/ordering_host.sv - host initiator streaming orderings to/from the replica ordering port
// Optional byte-sum accumulator on checksum under ORDERING_HOST_CHECKSUM_EN.
module ordering_host
    import replica_pkg::*;
#(
    parameter int replica_num       = 32,
    parameter int beats_per_replica = ORD_BEATS,
    parameter int fifo_depth        = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_write,
    input  logic           cmd_read,
    output logic           busy,
    output logic           done,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [63:0]    s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [63:0]    m_data,
    output logic           ordering_write,
    output ordering_word_t ordering_wdata,
    output logic           ordering_read,
    input  logic           ordering_ready,
    input  ordering_word_t ordering_rdata,
    output logic [15:0]    checksum
);

    localparam int T   = replica_num * beats_per_replica;
    localparam int CW  = $clog2(T + 1);
    localparam int FCW = $clog2(fifo_depth + 1);
    localparam logic [CW-1:0]  T_C     = CW'(T);
    localparam logic [FCW:0]   DEPTH_C = (FCW + 1)'(fifo_depth);

    ord_state_e     state_q, state_d;
    logic [CW-1:0]  wcnt_q, wcnt_d;
    logic [CW-1:0]  rcnt_q, rcnt_d;
    logic [CW-1:0]  pcnt_q, pcnt_d;
    logic           inflight_q;
    logic           start;
    logic           pop;
    logic           pop_read;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic [FCW:0]   credit_used;

    // Outstanding beats = buffered + the one the array is returning this cycle.
    assign credit_used = {1'b0, fifo_count} + (FCW + 1)'(inflight_q);
    assign m_valid     = !fifo_empty;
    assign pop         = m_valid && m_ready;
    assign pop_read    = pop && (state_q == ST_READ);
    assign busy        = (state_q != ST_IDLE);
    assign ordering_wdata = s_data;

    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        rcnt_d         = rcnt_q;
        pcnt_d         = pcnt_q;
        start          = 1'b0;
        s_ready        = 1'b0;
        ordering_write = 1'b0;
        ordering_read  = 1'b0;
        done           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_write) begin
                    state_d = ST_WRITE;
                    start   = 1'b1;
                end else if (cmd_read) begin
                    state_d = ST_READ;
                    start   = 1'b1;
                end
            end
            ST_WRITE: begin
                s_ready        = ordering_ready && (wcnt_q < T_C);
                ordering_write = s_valid && s_ready;
                if (ordering_write) begin
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_d == T_C) state_d = ST_DONE;
                end
            end
            ST_READ: begin
                ordering_read = ordering_ready && (rcnt_q < T_C) && (credit_used < DEPTH_C);
                if (ordering_read) rcnt_d = rcnt_q + CW'(1);
                if (pop) begin
                    pcnt_d = pcnt_q + CW'(1);
                    if (pcnt_d == T_C) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            wcnt_d = '0;
            rcnt_d = '0;
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            pcnt_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            pcnt_q     <= pcnt_d;
            inflight_q <= ordering_read;
        end
    end

    ordering_host_fifo #(
        .depth (fifo_depth),
        .width (64)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q),
        .din_i   (ordering_rdata),
        .pop_i   (pop),
        .dout_o  (m_data),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

`ifdef ORDERING_HOST_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start) begin
            csum_d = '0;
        end else if (ordering_write) begin
            csum_d = csum_q + byte_sum(s_data);
        end else if (pop_read) begin
            csum_d = csum_q + byte_sum(m_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    logic unused_pop_read;
    assign unused_pop_read = pop_read;
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ordering_host.sv
// tb/tb_ordering_host.sv - scoreboard bench for ordering_host (T = 2 replicas x 4 beats)
module tb_ordering_host;
    import replica_pkg::*;

    localparam int T = 8;

    logic           clk = 1'b0;
    logic           reset, cmd_write, cmd_read, s_valid, m_ready, ordering_ready;
    logic [63:0]    s_data;
    ordering_word_t ordering_rdata;
    logic           busy, done, s_ready, m_valid, ordering_write, ordering_read;
    logic [63:0]    m_data;
    ordering_word_t ordering_wdata;
    logic [15:0]    checksum;

    always #5 clk = ~clk;

    ordering_host #(
        .replica_num       (2),
        .beats_per_replica (4),
        .fifo_depth        (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_write      (cmd_write),
        .cmd_read       (cmd_read),
        .busy           (busy),
        .done           (done),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .ordering_write (ordering_write),
        .ordering_wdata (ordering_wdata),
        .ordering_read  (ordering_read),
        .ordering_ready (ordering_ready),
        .ordering_rdata (ordering_rdata),
        .checksum       (checksum)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [63:0] arr_mem [T];
    int arr_idx;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int n_wr, n_rd, n_pop, n_done;
    int first_wr, last_wr, first_rd, first_mv, first_pop, last_pop;
    logic acc_w;
    logic smp_busy, smp_done, smp_sready, smp_ready, smp_mvalid, smp_wr, smp_rd;
    logic [15:0] smp_cs;

    function automatic logic [15:0] model_sum(input logic [63:0] w);
        logic [15:0] s;
        s = 16'h0;
        for (int k = 0; k < 8; k++) s = s + {8'h00, w[8*k +: 8]};
        return s;
    endfunction

    function automatic logic [63:0] beat(input int i);
        return 64'h0706050403020100 + 64'(i);
    endfunction

    task automatic clear_stats();
        exp_q.delete();
        obs_q.delete();
        n_wr = 0; n_rd = 0; n_pop = 0; n_done = 0;
        first_wr = -1; last_wr = -1; first_rd = -1;
        first_mv = -1; first_pop = -1; last_pop = -1;
        arr_idx = 0;
    endtask

    // One clock: sample at negedge+1, then model the array's one-cycle read return.
    task automatic tick();
        logic rd_fire;
        #1;
        smp_busy   = busy;
        smp_done   = done;
        smp_sready = s_ready;
        smp_ready  = ordering_ready;
        smp_mvalid = m_valid;
        smp_wr     = ordering_write;
        smp_rd     = ordering_read;
        smp_cs     = checksum;
        acc_w      = ordering_write;
        if (ordering_write) begin
            n_wr++;
            obs_q.push_back(ordering_wdata);
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        rd_fire = ordering_read;
        if (ordering_read) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
            n_pop++;
            obs_q.push_back(m_data);
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (done) n_done++;
        @(negedge clk);
        cyc++;
        if (rd_fire && arr_idx < T) begin
            ordering_rdata = arr_mem[arr_idx];
            exp_q.push_back(arr_mem[arr_idx]);
            arr_idx++;
        end else begin
            ordering_rdata = 64'hdead_beef_0bad_f00d;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_write = 1'b0; cmd_read = 1'b0;
        s_valid = 1'b1; s_data = 64'h0; m_ready = 1'b1; ordering_ready = 1'b1;
        ordering_rdata = '0;
        @(negedge clk);
        tick(); tick(); tick();
        vectors++; if (smp_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", smp_busy); end
        vectors++; if (smp_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", smp_done); end
        vectors++; if (smp_sready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready got %b want 0", smp_sready); end
        vectors++; if (smp_mvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got %b want 0", smp_mvalid); end
        vectors++; if (smp_wr !== 1'b0 || smp_rd !== 1'b0) begin miscompares++; $display("FAIL reset_strobes got wr=%b rd=%b want 0", smp_wr, smp_rd); end
        vectors++; if (smp_cs !== 16'h0) begin miscompares++; $display("FAIL reset_checksum got %h want 0", smp_cs); end
        reset = 1'b0; s_valid = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int i, c0;
        logic [15:0] esum;
        logic [63:0] e, o;
        clear_stats();
        ordering_ready = 1'b1; m_ready = 1'b0; esum = 16'h0;
        c0 = cyc;
        cmd_write = 1'b1; tick(); cmd_write = 1'b0;
        i = 0; s_valid = 1'b1; s_data = beat(0);
        for (int c = 0; c < 40 && n_done == 0; c++) begin
            tick();
            if (acc_w) begin
                exp_q.push_back(beat(i));
                esum = esum + model_sum(beat(i));
                i++;
                s_data = beat(i);
            end
        end
        s_valid = 1'b0;
        vectors++; if (first_wr !== c0 + 1) begin miscompares++; $display("FAIL wr_first_cycle got %0d want %0d", first_wr, c0 + 1); end
        vectors++; if (last_wr - first_wr !== 7) begin miscompares++; $display("FAIL wr_back_to_back span got %0d want 7", last_wr - first_wr); end
        vectors++; if (n_wr !== T) begin miscompares++; $display("FAIL wr_count got %0d want %0d", n_wr, T); end
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL wr_done got %0d want 1", n_done); end
        vectors++; if (smp_busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy_in_done got %b want 1", smp_busy); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++; if (o !== e) begin miscompares++; $display("FAIL wr_data got %h want %h", o, e); end
        end
        tick(); tick();
        vectors++; if (smp_busy !== 1'b0) begin miscompares++; $display("FAIL wr_idle_busy got %b want 0", smp_busy); end
`ifdef ORDERING_HOST_CHECKSUM_EN
        vectors++; if (smp_cs !== esum) begin miscompares++; $display("FAIL wr_checksum got %h want %h", smp_cs, esum); end
`else
        vectors++; if (smp_cs !== 16'h0) begin miscompares++; $display("FAIL wr_checksum_off got %h want 0 (model %h)", smp_cs, esum); end
`endif
    endtask

    task automatic test_write_toggle();
        int i;
        logic [63:0] e, o;
        clear_stats();
        ordering_ready = 1'b0; m_ready = 1'b0;
        cmd_write = 1'b1; tick(); cmd_write = 1'b0;
        i = 0; s_valid = 1'b1; s_data = beat(0);
        for (int c = 0; c < 60 && n_done == 0; c++) begin
            ordering_ready = ~ordering_ready;
            tick();
            if (smp_busy && !smp_done) begin
                vectors++; if (smp_sready !== smp_ready) begin miscompares++; $display("FAIL tog_s_ready got %b want %b", smp_sready, smp_ready); end
            end
            if (acc_w) begin
                exp_q.push_back(beat(i));
                i++;
                s_data = beat(i);
            end
        end
        s_valid = 1'b0; ordering_ready = 1'b1;
        vectors++; if (n_wr !== T) begin miscompares++; $display("FAIL tog_count got %0d want %0d", n_wr, T); end
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL tog_done got %0d want 1", n_done); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++; if (o !== e) begin miscompares++; $display("FAIL tog_data got %h want %h", o, e); end
        end
        tick();
    endtask

    task automatic test_read_backpressure();
        logic [15:0] esum;
        logic [63:0] e, o;
        clear_stats();
        esum = 16'h0;
        for (int k = 0; k < T; k++) begin
            arr_mem[k] = {$urandom, $urandom};
            esum = esum + model_sum(arr_mem[k]);
        end
        ordering_ready = 1'b1; m_ready = 1'b0;
        cmd_read = 1'b1; tick(); cmd_read = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        vectors++; if (n_rd !== 4) begin miscompares++; $display("FAIL bp_issued got %0d want 4", n_rd); end
        vectors++; if (smp_mvalid !== 1'b1) begin miscompares++; $display("FAIL bp_m_valid got %b want 1", smp_mvalid); end
        m_ready = 1'b1;
        for (int c = 0; c < 60 && n_done == 0; c++) tick();
        m_ready = 1'b0;
        vectors++; if (n_rd !== T) begin miscompares++; $display("FAIL bp_reads got %0d want %0d", n_rd, T); end
        vectors++; if (n_pop !== T) begin miscompares++; $display("FAIL bp_pops got %0d want %0d", n_pop, T); end
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL bp_done got %0d want 1", n_done); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++; if (o !== e) begin miscompares++; $display("FAIL bp_data got %h want %h", o, e); end
        end
        tick();
`ifdef ORDERING_HOST_CHECKSUM_EN
        vectors++; if (smp_cs !== esum) begin miscompares++; $display("FAIL bp_checksum got %h want %h", smp_cs, esum); end
`else
        vectors++; if (smp_cs !== 16'h0) begin miscompares++; $display("FAIL bp_checksum_off got %h want 0 (model %h)", smp_cs, esum); end
`endif
    endtask

    task automatic test_read_stream();
        int c0;
        clear_stats();
        for (int k = 0; k < T; k++) arr_mem[k] = {$urandom, $urandom};
        ordering_ready = 1'b1; m_ready = 1'b1;
        c0 = cyc;
        cmd_read = 1'b1; tick(); cmd_read = 1'b0;
        for (int c = 0; c < 40 && n_done == 0; c++) tick();
        vectors++; if (first_rd !== c0 + 1) begin miscompares++; $display("FAIL rs_first_read got %0d want %0d", first_rd, c0 + 1); end
        vectors++; if (first_mv - first_rd !== 2) begin miscompares++; $display("FAIL rs_latency got %0d want 2", first_mv - first_rd); end
        vectors++; if (last_pop - first_pop !== 7) begin miscompares++; $display("FAIL rs_throughput span got %0d want 7", last_pop - first_pop); end
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL rs_done got %0d want 1", n_done); end
        m_ready = 1'b0;
        tick();
    endtask

    task automatic test_both_cmds();
        int i;
        logic [63:0] e, o;
        clear_stats();
        ordering_ready = 1'b1; m_ready = 1'b1;
        cmd_write = 1'b1; cmd_read = 1'b1; tick();
        cmd_write = 1'b0; cmd_read = 1'b0;
        i = 0; s_valid = 1'b1; s_data = beat(0);
        for (int c = 0; c < 40 && n_done == 0; c++) begin
            cmd_read = (c == 3);
            tick();
            if (acc_w) begin
                exp_q.push_back(beat(i));
                i++;
                s_data = beat(i);
            end
        end
        cmd_read = 1'b0; s_valid = 1'b0;
        tick(); tick();
        vectors++; if (n_rd !== 0) begin miscompares++; $display("FAIL both_reads got %0d want 0", n_rd); end
        vectors++; if (n_wr !== T) begin miscompares++; $display("FAIL both_writes got %0d want %0d", n_wr, T); end
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL both_done got %0d want 1", n_done); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++; if (o !== e) begin miscompares++; $display("FAIL both_data got %h want %h", o, e); end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset_midread();
        logic [63:0] e, o;
        int mv_seen;
        clear_stats();
        for (int k = 0; k < T; k++) arr_mem[k] = {$urandom, $urandom};
        ordering_ready = 1'b1; m_ready = 1'b1;
        cmd_read = 1'b1; tick(); cmd_read = 1'b0;
        for (int c = 0; c < 30 && n_pop < 3; c++) tick();
        vectors++; if (n_pop !== 3) begin miscompares++; $display("FAIL rst_pre_pops got %0d want 3", n_pop); end
        m_ready = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        n_done = 0; mv_seen = 0;
        tick();
        vectors++; if (smp_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", smp_busy); end
        vectors++; if (smp_mvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid got %b want 0", smp_mvalid); end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (smp_mvalid) mv_seen++;
        end
        vectors++; if (n_done !== 0 || mv_seen !== 0) begin miscompares++; $display("FAIL rst_quiet got done=%0d m_valid=%0d want 0/0", n_done, mv_seen); end
        clear_stats();
        m_ready = 1'b1;
        cmd_read = 1'b1; tick(); cmd_read = 1'b0;
        for (int c = 0; c < 40 && n_done == 0; c++) tick();
        vectors++; if (n_pop !== T) begin miscompares++; $display("FAIL rst_reread_pops got %0d want %0d", n_pop, T); end
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL rst_reread_done got %0d want 1", n_done); end
        for (int k = 0; k < T && obs_q.size() > 0; k++) begin
            e = arr_mem[k]; o = obs_q.pop_front();
            vectors++; if (o !== e) begin miscompares++; $display("FAIL rst_reread_data got %h want %h", o, e); end
        end
        m_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_toggle();
        test_read_backpressure();
        test_read_stream();
        test_both_cmds();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
